// File: rtl/uart_loader.sv
// uart_loader: boot loader that reads a word count and N words through the UART manager,
// writes them to instruction memory at consecutive addresses, then transmits an ack byte.
module uart_loader #(
  parameter int         ADDR_WIDTH = 15,
  parameter logic [7:0] ACK_BYTE   = 8'hAA
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  output logic                  busy,
  output logic                  finished,
  output logic                  overflow,
  output logic [31:0]           words_loaded,
  output logic                  order,
  input  logic                  accepted,
  input  logic                  done,
  output logic [1:0]            size,
  output logic                  write_flag,
  output logic [31:0]           write_data,
  input  logic [31:0]           read_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata
);
  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] LEN_REQ   = 4'd1;
  localparam logic [3:0] LEN_WAIT  = 4'd2;
  localparam logic [3:0] DATA_REQ  = 4'd3;
  localparam logic [3:0] DATA_WAIT = 4'd4;
  localparam logic [3:0] WRITE     = 4'd5;
  localparam logic [3:0] ACK_REQ   = 4'd6;
  localparam logic [3:0] ACK_WAIT  = 4'd7;
  localparam logic [3:0] DONE      = 4'd8;
  localparam logic [32:0] DEPTH = 33'(1) << ADDR_WIDTH;
  logic [3:0]  state, nxt;
  logic [31:0] n, index;
  logic        in_range, restart, last;
  assign in_range = {1'b0, index} < DEPTH;
  assign restart  = (state == IDLE || state == DONE) && start;
  assign last     = index + 32'd1 == n;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = start ? LEN_REQ : state;
      LEN_REQ:    nxt = accepted ? LEN_WAIT : state;
      LEN_WAIT:   nxt = !done ? state : read_data == 32'd0 ? ACK_REQ : DATA_REQ;
      DATA_REQ:   nxt = accepted ? DATA_WAIT : state;
      DATA_WAIT:  nxt = done ? WRITE : state;
      WRITE:      nxt = last ? ACK_REQ : DATA_REQ;
      ACK_REQ:    nxt = accepted ? ACK_WAIT : state;
      ACK_WAIT:   nxt = done ? DONE : state;
      default:    nxt = IDLE;
    endcase
  end
  // Outputs are registered from the next state, so order never sees accepted combinationally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      n            <= '0;
      index        <= '0;
      busy         <= 1'b0;
      finished     <= 1'b0;
      overflow     <= 1'b0;
      words_loaded <= '0;
      order        <= 1'b0;
      size         <= 2'b00;
      write_flag   <= 1'b0;
      write_data   <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      state    <= nxt;
      busy     <= nxt != IDLE && nxt != DONE;
      finished <= nxt == DONE;
      order    <= nxt == LEN_REQ || nxt == DATA_REQ || nxt == ACK_REQ;
      mem_we   <= state == DATA_WAIT && done && in_range;
      if (nxt == LEN_REQ || nxt == DATA_REQ) begin
        size       <= 2'b10;
        write_flag <= 1'b0;
        write_data <= '0;
      end
      if (nxt == ACK_REQ) begin
        size       <= 2'b00;
        write_flag <= 1'b1;
        write_data <= {24'b0, ACK_BYTE};
      end
      if (restart) begin
        words_loaded <= '0;
        overflow     <= 1'b0;
        index        <= '0;
        n            <= '0;
      end
      if (state == LEN_WAIT && done) n <= read_data;
      if (state == DATA_WAIT && done) begin
        mem_addr  <= index[ADDR_WIDTH-1:0];
        mem_wdata <= read_data;
      end
      // Words past the memory end are still consumed from the host but never written.
      if (state == WRITE) begin
        index        <= index + 32'd1;
        words_loaded <= words_loaded + 32'd1;
        overflow     <= overflow | !in_range;
      end
    end
  end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: loads driven by a behavioural UART/host model; each load is checked
// against the expected memory image, counters, ack byte and handshake timing.
module tb_uart_loader;
  typedef struct {
    logic sel;
    int   n;
    int   stall;
    int   lat;
    logic fixed;
    logic poke;
    int   exp_writes;
    logic exp_ovf;
  } load_t;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, done = 1'b0, acc_en = 1'b0, sel = 1'b0;
  logic [31:0] read_data = '0;
  logic accepted;
  always #5 clk = ~clk;
  logic busy_a, fin_a, ovf_a, order_a, wf_a, we_a;
  logic busy_b, fin_b, ovf_b, order_b, wf_b, we_b;
  logic [1:0]  size_a, size_b, ma_b;
  logic [31:0] wl_a, wd_a, md_a, wl_b, wd_b, md_b;
  logic [14:0] ma_a;
  logic busy, finished, overflow, order, write_flag, mem_we, any_out;
  logic [1:0]  size;
  logic [31:0] words_loaded, write_data, mem_wdata;
  logic [14:0] mem_addr;
  assign busy         = sel ? busy_b : busy_a;
  assign finished     = sel ? fin_b : fin_a;
  assign overflow     = sel ? ovf_b : ovf_a;
  assign order        = sel ? order_b : order_a;
  assign write_flag   = sel ? wf_b : wf_a;
  assign mem_we       = sel ? we_b : we_a;
  assign size         = sel ? size_b : size_a;
  assign words_loaded = sel ? wl_b : wl_a;
  assign write_data   = sel ? wd_b : wd_a;
  assign mem_wdata    = sel ? md_b : md_a;
  assign mem_addr     = sel ? {13'b0, ma_b} : ma_a;
  assign accepted     = order && acc_en;
  assign any_out = |{busy, finished, overflow, order, write_flag, mem_we, size, words_loaded,
                     write_data, mem_wdata, mem_addr};
  uart_loader dut_a (
    .clk(clk), .rstn(rstn), .start(start && !sel), .busy(busy_a), .finished(fin_a),
    .overflow(ovf_a), .words_loaded(wl_a), .order(order_a), .accepted(accepted && !sel),
    .done(done && !sel), .size(size_a), .write_flag(wf_a), .write_data(wd_a),
    .read_data(read_data), .mem_we(we_a), .mem_addr(ma_a), .mem_wdata(md_a)
  );
  uart_loader #(.ADDR_WIDTH(2)) dut_b (
    .clk(clk), .rstn(rstn), .start(start && sel), .busy(busy_b), .finished(fin_b),
    .overflow(ovf_b), .words_loaded(wl_b), .order(order_b), .accepted(accepted && sel),
    .done(done && sel), .size(size_b), .write_flag(wf_b), .write_data(wd_b),
    .read_data(read_data), .mem_we(we_b), .mem_addr(ma_b), .mem_wdata(md_b)
  );
  int stall = 0, lat = 1, n_acc = 0, op_idx = 0, proto_err = 0, gap_err = 0;
  int cyc = 0, done_cyc = 0, pass_cnt = 0, total = 0;
  logic [7:0]  host_q[$];
  logic [31:0] tx_q[$], wa_q[$], wd_q[$], exp_w[$];
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    @(negedge clk);
    if (mem_we) begin
      wa_q.push_back(32'(mem_addr));
      wd_q.push_back(mem_wdata);
    end
  end
  // UART manager + host: accepts after `stall` cycles, completes `lat` cycles later.
  initial begin : uart_model
    logic [1:0]  sz;
    logic        wf;
    logic [31:0] wd;
    @(negedge clk);
    forever begin
      while (!(rstn && order)) @(negedge clk);
      if (op_idx > 0 && cyc - done_cyc != (op_idx == 1 ? 1 : 2)) gap_err++;
      sz = size;
      wf = write_flag;
      wd = write_data;
      if (sz != (wf ? 2'b00 : 2'b10)) proto_err++;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (!order || size != sz || write_flag != wf || write_data != wd) proto_err++;
      end
      acc_en = 1'b1;
      @(negedge clk);
      acc_en = 1'b0;
      n_acc++;
      if (order) proto_err++;
      repeat (lat) @(negedge clk);
      if (wf) tx_q.push_back(wd);
      else if (host_q.size() < 4) proto_err++;
      else for (int k = 0; k < 4; k++) read_data = {read_data[23:0], host_q.pop_front()};
      done = 1'b1;
      done_cyc = cyc;
      op_idx++;
      @(negedge clk);
      done = 1'b0;
      read_data = '0;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask
  task automatic prep(input load_t v);
    logic [31:0] w;
    sel = v.sel;
    stall = v.stall;
    lat = v.lat;
    host_q.delete(); tx_q.delete(); wa_q.delete(); wd_q.delete(); exp_w.delete();
    n_acc = 0; op_idx = 0; proto_err = 0; gap_err = 0;
    w = v.n;
    for (int k = 3; k >= 0; k--) host_q.push_back(w[8*k +: 8]);
    for (int i = 0; i < v.n; i++) begin
      w = v.fixed ? (i == 0 ? 32'h01020304 : 32'hDEADBEEF) : $urandom;
      exp_w.push_back(w);
      for (int k = 3; k >= 0; k--) host_q.push_back(w[8*k +: 8]);
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic run_load(input load_t v, input int id);
    int t, bad;
    prep(v);
    chk($sformatf("L%0d busy", id), 32'(busy), 32'd1);
    if (v.poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (!finished && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("L%0d timeout", id), 32'(t < 3000), 32'd1);
    chk($sformatf("L%0d busy_end", id), 32'(busy), 32'd0);
    chk($sformatf("L%0d words_loaded", id), words_loaded, v.n);
    chk($sformatf("L%0d overflow", id), 32'(overflow), 32'(v.exp_ovf));
    chk($sformatf("L%0d writes", id), wa_q.size(), v.exp_writes);
    bad = 0;
    for (int i = 0; i < wa_q.size() && i < exp_w.size(); i++)
      if (wa_q[i] != i || wd_q[i] != exp_w[i]) bad++;
    chk($sformatf("L%0d mem_bad", id), bad, 32'd0);
    chk($sformatf("L%0d tx_count", id), tx_q.size(), 32'd1);
    chk($sformatf("L%0d tx_byte", id), tx_q.size() > 0 ? tx_q[0] : 32'hFFFFFFFF, 32'hAA);
    chk($sformatf("L%0d accepts", id), n_acc, v.n + 2);
    chk($sformatf("L%0d proto_err", id), proto_err, 32'd0);
    chk($sformatf("L%0d gap_err", id), gap_err, 32'd0);
  endtask
  load_t tbl[8];
  initial begin
    load_t v;
    int t;
    //          sel   n  stall lat fixed poke  writes ovf
    tbl[0] = '{1'b0, 2, 0, 1, 1'b1, 1'b0, 2, 1'b0};
    tbl[1] = '{1'b0, 0, 0, 1, 1'b0, 1'b0, 0, 1'b0};
    tbl[2] = '{1'b0, 2, 7, 3, 1'b1, 1'b0, 2, 1'b0};
    tbl[3] = '{1'b1, 6, 0, 1, 1'b0, 1'b1, 4, 1'b1};
    tbl[4] = '{1'b1, 4, 2, 0, 1'b0, 1'b0, 4, 1'b0};
    tbl[5] = '{1'b0, 5, 1, 2, 1'b0, 1'b1, 5, 1'b0};
    tbl[6] = '{1'b1, 5, 0, 2, 1'b0, 1'b0, 4, 1'b1};
    tbl[7] = '{1'b0, 1, 3, 0, 1'b0, 1'b0, 1, 1'b0};
    #1 chk("reset_a", 32'(any_out), 32'd0);
    sel = 1'b1;
    #1 chk("reset_b", 32'(any_out), 32'd0);
    sel = 1'b0;
    @(negedge clk) rstn = 1'b1;
    for (int i = 0; i < 8; i++) run_load(tbl[i], i);
    for (int i = 0; i < 6; i++) begin
      v.sel = 1'($urandom_range(0, 1));
      v.n = $urandom_range(1, 9);
      v.stall = $urandom_range(0, 4);
      v.lat = $urandom_range(0, 3);
      v.fixed = 1'b0;
      v.poke = 1'($urandom_range(0, 1)) && v.n >= 2;
      v.exp_writes = (v.sel && v.n > 4) ? 4 : v.n;
      v.exp_ovf = v.sel && v.n > 4;
      run_load(v, 10 + i);
    end
    v = '{1'b0, 3, 0, 3, 1'b0, 1'b0, 3, 1'b0};
    prep(v);
    t = 0;
    while (n_acc < 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reach", 32'(n_acc >= 3), 32'd1);
    #2 rstn = 1'b0;
    #1 chk("rst_async", 32'(any_out), 32'd0);
    repeat (10) @(negedge clk);
    chk("rst_no_write", wa_q.size(), 32'd1);
    chk("rst_no_order", n_acc, 32'd3);
    rstn = 1'b1;
    run_load(tbl[0], 20);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
